// File: rtl/req_enc_pkg.sv
// req_enc_pkg -- shared constants, state encoding and helpers for the
// 8-way request encoder.
//   NUM_REQ : number of request lines (8)
//   IDX_W   : width of an encoded request index (3)
//   state_e : offer FSM states (IDLE, OFFER)
//   onehot(): index -> one-hot request mask
package req_enc_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/prio_encoder8_3.sv
// prio_encoder8_3 -- combinational circular priority encoder.
// Searches vec upward from bit 'start', wrapping 7->0, and returns the
// first set position. Fixed-priority users tie start to 0.
//   vec   : in  8  candidate request bits
//   start : in  3  first index to examine
//   idx   : out 3  index of first set bit at or after start (circular)
//   found : out 1  any bit of vec is set
module prio_encoder8_3
  import req_enc_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     ofs;

  // Rotate so that 'start' lands at bit 0; the lowest set bit of rot is
  // then the winner, expressed as an offset from start.
  assign dbl = {vec, vec} >> start;
  assign rot = dbl[NUM_REQ-1:0];

  always_comb begin
    ofs   = '0;
    found = 1'b0;
    // Scan high to low so the lowest set offset is the last assignment.
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (rot[i]) begin
        ofs   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  // Offset back to absolute index; 3-bit add wraps naturally.
  assign idx = start + ofs;

endmodule

// File: rtl/req_encoder8_3.sv
// req_encoder8_3 -- pending-request collector with a valid/ready offer port.
// Request bits accumulate in 'pending'; one index at a time is offered on
// out_idx/out_valid and its pending bit is cleared on the handshake edge
// (unless re-requested that same cycle, in which case it stays set).
// Back-to-back grants are issued one per cycle while work remains.
//
// Build option: define REQ_ENCODER_ROUND_ROBIN_EN for round-robin selection
// (search upward from a pointer that moves past each granted index).
// Without it, selection is fixed priority, lowest index first.
//
// Ports:
//   clk       : in  1  rising-edge clock
//   reset     : in  1  asynchronous active-high reset
//   req_in    : in  8  request bits, ORed into pending each cycle
//   out_idx   : out 3  registered index of the current offer
//   out_valid : out 1  an offer is present
//   out_ready : in  1  consumer accepts the offer
//   pending   : out 8  pending-request register
module req_encoder8_3
  import req_enc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] pending
);

  state_e             state, state_nxt;
  logic               hs;
  logic [NUM_REQ-1:0] clr, pend_nxt;
  logic [IDX_W-1:0]   idx_nxt, sel_idx, sel_start;
  logic               sel_found;

  assign out_valid = (state == OFFER);
  assign hs        = out_valid & out_ready;

  // Clear only on a real handshake; OR of req_in after the clear makes a
  // same-cycle re-request win over the clear.
  assign clr      = hs ? onehot(out_idx) : '0;
  assign pend_nxt = (pending & ~clr) | req_in;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr, rr_nxt;

  // The selection for the next offer must already see the advanced
  // pointer, otherwise a continuously re-requested index would win twice.
  assign rr_nxt    = hs ? out_idx + IDX_W'(1) : rr_ptr;
  assign sel_start = rr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr <= '0;
    else       rr_ptr <= rr_nxt;
  end
`else
  assign sel_start = '0;
`endif

  prio_encoder8_3 u_sel (
    .vec   (pend_nxt),
    .start (sel_start),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = out_idx;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt = OFFER;
          idx_nxt   = sel_idx;
        end
      end
      OFFER: begin
        // Without a handshake the offer is frozen, even if a higher
        // priority request shows up meanwhile.
        if (hs) begin
          if (sel_found) idx_nxt   = sel_idx;
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      out_idx <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      out_idx <= idx_nxt;
      pending <= pend_nxt;
    end
  end

endmodule
